// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding and
// counter width computation.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period; clr holds the count at zero.
module uart_baud_tick
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int TW = cnt_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] timer_q, timer_d;

  assign tick = (timer_q == LAST);

  always_comb begin
    timer_d = timer_q + TW'(1);
    if (clr || tick) timer_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word on a valid/ready handshake and sends a
// start bit, DATA_W data bits LSB first, then STOP_BITS stop bits on tx.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output uart_state_e       dbg_state
);

  // Handshake: a word transfers on a rising edge where valid && ready.
  // ready is high only in IDLE; valid/data are ignored at all other times.

  localparam int BW = cnt_width(DATA_W + 1);

  uart_state_e       state_q, state_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tick;

  // The timer is held cleared while idle, so acceptance starts a fresh period.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign tx        = tx_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (valid) begin
          shift_d = data;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          // tx is registered, so present the next bit one edge early.
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            state_d   = ST_STOP;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance with one stop bit, one with two; expected
// line levels are built per frame and compared every cycle.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int C  = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] data;
  logic          valid;
  logic          sel;  // 0: one-stop-bit DUT, 1: two-stop-bit DUT
  logic          valid_a, valid_b;
  logic          ready_a, tx_a, busy_a, ready_b, tx_b, busy_b;
  uart_state_e   st_a, st_b;
  logic          ready_s, tx_s, busy_s;

  assign valid_a = valid && !sel;
  assign valid_b = valid && sel;
  assign ready_s = sel ? ready_b : ready_a;
  assign tx_s    = sel ? tx_b : tx_a;
  assign busy_s  = sel ? busy_b : busy_a;

  uart_tx #(.CLKS_PER_BIT(C), .DATA_W(DW), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .data(data), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .dbg_state(st_a)
  );

  uart_tx #(.CLKS_PER_BIT(C), .DATA_W(DW), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .data(data), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame as a list of line levels, one per clock.
  task automatic push_level(input logic lvl, input int n);
    repeat (n) exp_q.push_back(lvl);
  endtask

  task automatic model_frame(input logic [DW-1:0] d, input int stop_bits);
    push_level(1'b0, C);
    for (int k = 0; k < DW; k++) push_level(d[k], C);
    push_level(1'b1, stop_bits * C);
  endtask

  // Hand-written frame: MSB is the first level on the line.
  task automatic table_frame(input logic [9:0] f);
    for (int i = 9; i >= 0; i--) push_level(f[i], C);
  endtask

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [DW-1:0] d);
    @(negedge clk);
    check("ready_before_accept", ready_s, 1);
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Called just after the accepting edge: drains exp_q one level per cycle,
  // then checks the single idle cycle that follows the frame.
  task automatic check_frame(input string name);
    int n;
    logic [0:0] e;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check({name, "_tx"}, tx_s, e);
      check({name, "_busy"}, busy_s, 1);
      check({name, "_ready"}, ready_s, 0);
    end
    @(negedge clk);
    check({name, "_idle_ready"}, ready_s, 1);
    check({name, "_idle_busy"}, busy_s, 0);
    check({name, "_idle_tx"}, tx_s, 1);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [9:0]    frame;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h00, 10'b0000000001};
    vecs[2] = '{8'hFF, 10'b0111111111};
    vecs[3] = '{8'h01, 10'b0100000001};
    vecs[4] = '{8'h80, 10'b0000000011};
    vecs[5] = '{8'h55, 10'b0101010101};
    vecs[6] = '{8'h3C, 10'b0001111001};

    data  = '0;
    valid = 1'b0;
    sel   = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", tx_a, 1);
    check("reset_ready", ready_a, 1);
    check("reset_busy", busy_a, 0);
    check("reset_state", st_a, ST_IDLE);
    rst = 1'b0;

    // Idle with no traffic, valid held low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tx", tx_a, 1);
      check("idle_ready", ready_a, 1);
      check("idle_busy", busy_a, 0);
    end

    // Table-driven frames on the one-stop-bit instance.
    for (int v = 0; v < 7; v++) begin
      table_frame(vecs[v].frame);
      accept(vecs[v].d);
      check_frame("table");
    end

    // valid held high: 0x00 then 0xFF, exactly one idle cycle apart.
    @(negedge clk);
    data  = 8'h00;
    valid = 1'b1;
    @(posedge clk);
    #1 data = 8'hFF;
    model_frame(8'h00, 1);
    check_frame("b2b_first");
    @(posedge clk);
    model_frame(8'hFF, 1);
    check_frame("b2b_second");
    valid = 1'b0;

    // Data/valid activity during a frame must not disturb it.
    table_frame(10'b0001111001);
    accept(8'h3C);
    fork
      check_frame("ignore");
      begin
        repeat (10) @(negedge clk);
        data  = 8'hFF;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
      end
    join
    @(negedge clk);
    check("ignore_no_second_busy", busy_a, 0);
    check("ignore_no_second_tx", tx_a, 1);

    // Two stop bits: 0x81 gives a 44-cycle frame with 8 cycles of stop.
    sel = 1'b1;
    push_level(1'b0, C);
    push_level(1'b1, C);
    push_level(1'b0, 6 * C);
    push_level(1'b1, C);
    push_level(1'b1, 2 * C);
    accept(8'h81);
    check_frame("stop2");

    // Reset in the middle of a frame.
    sel = 1'b0;
    accept(8'h00);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("pre_reset_tx", tx_a, 0);
    end
    #1 rst = 1'b1;
    #1;
    check("async_reset_tx", tx_a, 1);
    check("async_reset_ready", ready_a, 1);
    check("async_reset_busy", busy_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", ready_a, 1);
    check("post_reset_busy", busy_a, 0);
    check("post_reset_state", st_a, ST_IDLE);
    table_frame(10'b0101001011);
    accept(8'hA5);
    check_frame("after_reset");

    // Random bytes on both instances with random idle gaps.
    for (int r = 0; r < 24; r++) begin
      logic [DW-1:0] d;
      d   = DW'($urandom_range(0, 255));
      sel = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      model_frame(d, sel ? 2 : 1);
      accept(d);
      check_frame("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
